conv_window_engine: RTL and testbench
=====================================

CONV_WINDOW_ENGINE -- requirements
Module: conv_window_engine

Interface
REQ-001 SHALL provide parameter DATA_W, 8, signed pixel/weight width.
REQ-002 SHALL provide parameter ACC_W, 32, signed accumulator/result width.
REQ-003 SHALL provide parameter MAX_IMG, 8, max square image side.
REQ-004 SHALL provide parameter MAX_K, 4, max square kernel side.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle job request.
REQ-009 SHALL have port cfg_img, input, $clog2(MAX_IMG+1), image side N.
REQ-010 SHALL have port cfg_k, input, $clog2(MAX_K+1), kernel side K.
REQ-011 SHALL have port cfg_stride, input, 2, stride S (1..3).
REQ-012 SHALL have port cfg_relu, input, 1, clamp negative results to 0.
REQ-013 SHALL have port in_valid, input, 1, load beat valid.
REQ-014 SHALL have port in_ready, output, 1, engine accepts load beat.
REQ-015 SHALL have port in_data, input, DATA_W, signed weight or pixel.
REQ-016 SHALL have port out_valid, output, 1, result valid.
REQ-017 SHALL have port out_ready, input, 1, sink accepts result.
REQ-018 SHALL have port out_data, output, ACC_W, signed result.
REQ-019 SHALL have port out_last, output, 1, marks final result of job.
REQ-020 SHALL have port busy, output, 1, job in progress.
REQ-021 SHALL have port done, output, 1, one-cycle job-complete pulse.
REQ-022 SHALL have port cfg_err, output, 1, one-cycle bad-config pulse.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD_K, LOAD_I, MAC, OUT, FIN.
REQ-024 SHALL, in IDLE on start, latch N, K, S, relu; go to LOAD_K if 1<=K<=N<=MAX_IMG, K<=MAX_K, S!=0; otherwise pulse cfg_err, stay IDLE.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL assert in_ready only in LOAD_K/LOAD_I; a beat transfers when in_valid && in_ready.
REQ-027 SHALL store K*K weights row-major in LOAD_K, then N*N pixels row-major in LOAD_I; the cycle after the last pixel transfers, it enters MAC.
REQ-028 SHALL produce O*O outputs, O = floor((N-K)/S)+1, in row-major output order; window origin (r*S, c*S).
REQ-029 SHALL perform one signed DATA_W x DATA_W multiply-accumulate per MAC cycle: K*K cycles per output, accumulator cleared at window start, sign-extended to ACC_W, wrapping modulo 2^ACC_W.
REQ-030 SHALL assert out_valid the cycle after the final MAC cycle of a window (first out_valid K*K+1 cycles after last pixel accept).
REQ-031 SHALL apply relu (negative -> 0) to out_data when latched relu=1.
REQ-032 SHALL hold out_data, out_last, out_valid stable while out_valid && !out_ready; on accept, return to MAC for next window or go to FIN after last.
REQ-033 SHALL assert out_last only with the O*O-th result.
REQ-034 SHALL pulse done for one cycle in FIN, then return to IDLE; busy high in all states except IDLE.
REQ-035 SHALL retain buffer contents across jobs but recompute only from newly loaded data.

Reset
REQ-036 SHALL, on rst high at a clock edge, force IDLE and drive in_ready, out_valid, out_data, out_last, busy, done, cfg_err to 0 the following cycle, including mid-load, mid-MAC or mid-output; partial job discarded.
REQ-037 SHALL give rst priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-038 SHALL verify N=5,K=3,S=1, weights all 1, pixels 1..25, out_ready=1 -> 63,72,81,108,117,126,153,162,171; out_last on 171; done one cycle after its accept.
REQ-039 SHALL verify N=3,K=2,S=1, weights {1,0,0,1}, pixels 1..9 -> 6,8,12,14.
REQ-040 SHALL verify N=5,K=3,S=2, weights all 1, pixels 1..25 -> 63,81,153,171.
REQ-041 SHALL verify N=3,K=2, weights all 0xFF (-1), pixels 1..9: relu=0 -> -12,-16,-24,-28; relu=1 -> 0,0,0,0.
REQ-042 SHALL verify out_ready low 5 cycles at first result of REQ-038 -> out_data held 63, no loss or duplication, full sequence still correct; in_valid gaps during load -> identical results.
REQ-043 SHALL verify start with K=4,N=3 -> cfg_err pulse, busy stays 0; rst asserted mid-LOAD_I -> all outputs 0 next cycle, fresh job then correct.

Source files
------------

// File: rtl/conv_window_engine.sv
// Streaming 2-D convolution engine: loads a KxK kernel and an NxN image, then
// emits one strided, optionally ReLU-clamped window sum per handshake.
module conv_window_engine #(
   parameter int DATA_W  = 8,
   parameter int ACC_W   = 32,
   parameter int MAX_IMG = 8,
   parameter int MAX_K   = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [$clog2(MAX_IMG+1)-1:0]       cfg_img,
   input  logic [$clog2(MAX_K+1)-1:0]         cfg_k,
   input  logic [1:0]                         cfg_stride,
   input  logic                               cfg_relu,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic signed [DATA_W-1:0]           in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [ACC_W-1:0]            out_data,
   output logic                               out_last,
   output logic                               busy,
   output logic                               done,
   output logic                               cfg_err
);

   localparam int CW = $clog2(MAX_IMG*MAX_IMG);
   localparam int KW = $clog2(MAX_K*MAX_K);
   localparam int PW = 2*DATA_W;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_K = 3'd1;
   localparam logic [2:0] LOAD_I = 3'd2;
   localparam logic [2:0] MAC    = 3'd3;
   localparam logic [2:0] OUT    = 3'd4;
   localparam logic [2:0] FIN    = 3'd5;

   logic [2:0] state;
   logic signed [DATA_W-1:0] wbuf [MAX_K*MAX_K];
   logic signed [DATA_W-1:0] pbuf [MAX_IMG*MAX_IMG];
   logic [CW-1:0] n_r, k_r, s_r, ld_cnt, or_org, oc_org, kr, kc;
   logic relu_r;
   logic signed [ACC_W-1:0] acc;

   logic [7:0] img8, k8;
   logic cfg_ok;
   logic [KW-1:0] kw, kk_m1, w_addr;
   logic [CW-1:0] nn_m1, p_addr;
   logic signed [PW-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext, sum;
   logic win_end, col_fits, row_fits;

   assign img8   = 8'(cfg_img);
   assign k8     = 8'(cfg_k);
   assign cfg_ok = (k8 >= 8'd1) && (k8 <= img8) && (img8 <= 8'(MAX_IMG)) &&
                   (k8 <= 8'(MAX_K)) && (cfg_stride != 2'd0);

   // Element counts are taken modulo the buffer depth, so a full-size
   // kernel or image (e.g. 16 or 64 entries) still yields the right last index.
   assign kw     = k_r[KW-1:0];
   assign kk_m1  = kw * kw - KW'(1);
   assign nn_m1  = n_r * n_r - CW'(1);
   assign w_addr = kr[KW-1:0] * kw + kc[KW-1:0];
   assign p_addr = (or_org + kr) * n_r + oc_org + kc;

   assign prod     = PW'(wbuf[w_addr]) * PW'(pbuf[p_addr]);
   assign prod_ext = ACC_W'(prod);
   assign sum      = acc + prod_ext;

   assign win_end  = (kc == k_r - CW'(1)) && (kr == k_r - CW'(1));
   assign col_fits = (oc_org + s_r + k_r) <= n_r;
   assign row_fits = (or_org + s_r + k_r) <= n_r;

   assign in_ready  = (state == LOAD_K) || (state == LOAD_I);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cfg_err  <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         ld_cnt   <= '0;
         or_org   <= '0;
         oc_org   <= '0;
         kr       <= '0;
         kc       <= '0;
         acc      <= '0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_r    <= CW'(cfg_img);
                  k_r    <= CW'(cfg_k);
                  s_r    <= CW'(cfg_stride);
                  relu_r <= cfg_relu;
                  ld_cnt <= '0;
                  if (cfg_ok) state <= LOAD_K;
                  else        cfg_err <= 1'b1;
               end
            end
            LOAD_K: begin
               if (in_valid) begin
                  wbuf[ld_cnt[KW-1:0]] <= in_data;
                  if (ld_cnt == CW'(kk_m1)) begin
                     ld_cnt <= '0;
                     state  <= LOAD_I;
                  end else begin
                     ld_cnt <= ld_cnt + CW'(1);
                  end
               end
            end
            LOAD_I: begin
               if (in_valid) begin
                  pbuf[ld_cnt] <= in_data;
                  if (ld_cnt == nn_m1) begin
                     ld_cnt   <= '0;
                     or_org   <= '0;
                     oc_org   <= '0;
                     kr       <= '0;
                     kc       <= '0;
                     acc      <= '0;
                     out_last <= 1'b0;
                     state    <= MAC;
                  end else begin
                     ld_cnt <= ld_cnt + CW'(1);
                  end
               end
            end
            MAC: begin
               if (win_end) begin
                  kr       <= '0;
                  kc       <= '0;
                  acc      <= '0;
                  out_data <= (relu_r && sum[ACC_W-1]) ? '0 : sum;
                  out_last <= !col_fits && !row_fits;
                  state    <= OUT;
               end else begin
                  acc <= sum;
                  if (kc == k_r - CW'(1)) begin
                     kc <= '0;
                     kr <= kr + CW'(1);
                  end else begin
                     kc <= kc + CW'(1);
                  end
               end
            end
            OUT: begin
               // Window origin advances along the row, then wraps to the next strided row.
               if (out_ready) begin
                  if (out_last) begin
                     state <= FIN;
                  end else begin
                     state <= MAC;
                     if (col_fits) begin
                        oc_org <= oc_org + s_r;
                     end else begin
                        oc_org <= '0;
                        or_org <= or_org + s_r;
                     end
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench for conv_window_engine: directed jobs push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_conv_window_engine;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 32;

   logic              clk;
   logic              rst;
   logic              start;
   logic [3:0]        cfg_img;
   logic [2:0]        cfg_k;
   logic [1:0]        cfg_stride;
   logic              cfg_relu;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              cfg_err;

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_data[$];
   bit exp_last[$];
   bit pending_done = 0;
   int stall_req = 0;
   int tw[16];
   int tp[64];

   conv_window_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_IMG(8), .MAX_K(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_img(cfg_img), .cfg_k(cfg_k), .cfg_stride(cfg_stride), .cfg_relu(cfg_relu),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_out(input int v, input bit last);
      exp_data.push_back(v);
      exp_last.push_back(last);
   endtask

   task automatic fill_weights(input int cnt, input int v);
      for (int i = 0; i < cnt; i++) tw[i] = v;
   endtask

   task automatic fill_pixels(input int cnt);
      for (int i = 0; i < cnt; i++) tp[i] = i + 1;
   endtask

   // One complete job: config pulse, weight+pixel stream (optionally gappy),
   // first-result latency, then wait for the engine to go idle.
   task automatic applyStimulus(input int n, input int k, input int s, input bit relu, input bit gap);
      int kk, total, i, cyc, lat, wt;
      bit xfer;
      kk = k * k;
      total = kk + n * n;
      cfg_img = 4'(n);
      cfg_k = 3'(k);
      cfg_stride = 2'(s);
      cfg_relu = relu;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      i = 0;
      cyc = 0;
      while (i < total && cyc < 1000) begin
         in_valid = !(gap && (cyc % 3 == 1));
         in_data = (i < kk) ? 8'(tw[i]) : 8'(tp[i - kk]);
         xfer = in_valid && in_ready;
         @(negedge clk);
         if (xfer) i++;
         cyc++;
      end
      in_valid = 1'b0;
      checkOutput("load_beats", i, total);
      lat = 0;
      while (!out_valid && lat < 500) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("first_latency", lat, kk);
      wt = 0;
      while (busy && wt < 2000) begin
         @(negedge clk);
         wt++;
      end
      checkOutput("job_idle", longint'(busy), 0);
   endtask

   // Sink: holds out_ready low for stall_req cycles once a result is offered.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid && stall_req > 0) begin
            out_ready = 1'b0;
            stall_req--;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: compares every offered result against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (pending_done) begin
            checkOutput("done_pulse", longint'(done), 1);
            pending_done = 0;
         end
         if (!rst && out_valid) begin
            if (exp_data.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("[TB] FAIL unexpected_out: got %0d expected no result", $signed(out_data));
            end else if (!out_ready) begin
               checkOutput("held_data", longint'($signed(out_data)), exp_data[0]);
            end else begin
               checkOutput("out_data", longint'($signed(out_data)), exp_data[0]);
               checkOutput("out_last", longint'(out_last), longint'(exp_last[0]));
               if (exp_last[0]) pending_done = 1;
               void'(exp_data.pop_front());
               void'(exp_last.pop_front());
            end
         end
      end
   end

   task automatic expect_job_a();
      expect_out(63, 0);  expect_out(72, 0);  expect_out(81, 0);
      expect_out(108, 0); expect_out(117, 0); expect_out(126, 0);
      expect_out(153, 0); expect_out(162, 0); expect_out(171, 1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      cfg_img = '0;
      cfg_k = '0;
      cfg_stride = '0;
      cfg_relu = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", longint'(in_ready), 0);
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_out_data", longint'(out_data), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_done", longint'(done), 0);
      checkOutput("rst_cfg_err", longint'(cfg_err), 0);
      rst = 1'b0;
      @(negedge clk);

      fill_weights(9, 1);
      fill_pixels(25);
      expect_job_a();
      applyStimulus(5, 3, 1, 1'b0, 1'b0);

      tw[0] = 1; tw[1] = 0; tw[2] = 0; tw[3] = 1;
      fill_pixels(9);
      expect_out(6, 0); expect_out(8, 0); expect_out(12, 0); expect_out(14, 1);
      applyStimulus(3, 2, 1, 1'b0, 1'b0);

      fill_weights(9, 1);
      fill_pixels(25);
      expect_out(63, 0); expect_out(81, 0); expect_out(153, 0); expect_out(171, 1);
      applyStimulus(5, 3, 2, 1'b0, 1'b0);

      fill_weights(4, -1);
      fill_pixels(9);
      expect_out(-12, 0); expect_out(-16, 0); expect_out(-24, 0); expect_out(-28, 1);
      applyStimulus(3, 2, 1, 1'b0, 1'b0);
      expect_out(0, 0); expect_out(0, 0); expect_out(0, 0); expect_out(0, 1);
      applyStimulus(3, 2, 1, 1'b1, 1'b0);

      fill_weights(9, 1);
      fill_pixels(25);
      stall_req = 5;
      expect_job_a();
      applyStimulus(5, 3, 1, 1'b0, 1'b1);

      tw[0] = 1; tw[1] = 0; tw[2] = 0; tw[3] = 1;
      fill_pixels(9);
      expect_out(6, 0); expect_out(8, 0); expect_out(12, 0); expect_out(14, 1);
      applyStimulus(3, 2, 1, 1'b0, 1'b1);

      cfg_img = 4'd3;
      cfg_k = 3'd4;
      cfg_stride = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("cfg_err_pulse", longint'(cfg_err), 1);
      checkOutput("cfg_err_busy", longint'(busy), 0);
      @(negedge clk);
      checkOutput("cfg_err_clear", longint'(cfg_err), 0);
      checkOutput("cfg_err_idle", longint'(busy), 0);

      fill_weights(9, 1);
      fill_pixels(25);
      cfg_img = 4'd5;
      cfg_k = 3'd3;
      cfg_stride = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         in_valid = 1'b1;
         in_data = (i < 9) ? 8'(tw[i]) : 8'(tp[i - 9]);
         @(negedge clk);
      end
      checkOutput("midload_ready", longint'(in_ready), 1);
      checkOutput("midload_busy", longint'(busy), 1);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      checkOutput("abort_in_ready", longint'(in_ready), 0);
      checkOutput("abort_out_valid", longint'(out_valid), 0);
      checkOutput("abort_out_data", longint'(out_data), 0);
      checkOutput("abort_out_last", longint'(out_last), 0);
      checkOutput("abort_busy", longint'(busy), 0);
      checkOutput("abort_done", longint'(done), 0);
      checkOutput("abort_cfg_err", longint'(cfg_err), 0);
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);

      expect_job_a();
      applyStimulus(5, 3, 1, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      checkOutput("sb_drain", exp_data.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
